// File: rtl/mealy_seq_detector.sv
// Serial Mealy pattern detector with a combinational match flag, a wrapping or
// saturating match counter and a sticky overflow flag.
module mealy_seq_detector #(
  parameter int unsigned        PAT_W    = 4,
  parameter logic [PAT_W-1:0]   PATTERN  = 4'b1101,
  parameter bit                 OVERLAP  = 1'b1,
  parameter int unsigned        CNT_W    = 4,
  parameter bit                 SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             en,
  input  logic             clear,
  output logic [CNT_W-1:0] out,
  output logic             z,
  output logic             ovf
);

  localparam int unsigned HIST_W = PAT_W - 1;
  localparam int unsigned LEN_W  = $clog2(PAT_W);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(HIST_W);

  localparam logic [0:0] ST_FILL  = 1'b0;
  localparam logic [0:0] ST_ARMED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [HIST_W-1:0] hist_q, hist_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              match_c;

  // Zero-latency match: full history plus the bit currently on the wire.
  always_comb begin
    match_c = rst & en & (state_q == ST_ARMED) & ({hist_q, in} == PATTERN);
  end

  assign z   = match_c;
  assign out = cnt_q;
  assign ovf = ovf_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hist_d  = hist_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;

    if (en) begin
      if (match_c && !OVERLAP) begin
        hist_d  = '0;
        len_d   = '0;
        state_d = ST_FILL;
      end else begin
        hist_d = HIST_W'({hist_q, in});
        case (state_q)
          ST_FILL: begin
            len_d = len_q + LEN_W'(1);
            if (len_d == LEN_MAX) begin
              state_d = ST_ARMED;
            end
          end
          default: begin
            len_d   = LEN_MAX;
            state_d = ST_ARMED;
          end
        endcase
      end
    end

    // Clear beats a simultaneous match; it never touches the history.
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (match_c) begin
      if (cnt_q == '1) begin
        ovf_d = 1'b1;
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_FILL;
      len_q   <= '0;
      hist_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Self-checking bench: five detector configurations share one stimulus stream
// and are compared every cycle against a queue-based model of the matching rules.
module tb_mealy_seq_detector;

  localparam int N = 5;
  localparam int PW  [N] = '{4, 4, 4, 2, 5};
  localparam int PAT [N] = '{13, 13, 13, 3, 22};
  localparam int OVL [N] = '{1, 0, 1, 1, 0};
  localparam int CW  [N] = '{4, 4, 4, 2, 3};
  localparam int SAT [N] = '{0, 0, 1, 0, 1};

  logic clk = 1'b0;
  logic rst, in_b, en, clear;
  logic [3:0] out0, out1, out2;
  logic [1:0] out3;
  logic [2:0] out4;
  logic z0, z1, z2, z3, z4;
  logic ovf0, ovf1, ovf2, ovf3, ovf4;

  logic [15:0] out_a [N];
  logic        z_a   [N];
  logic        ovf_a [N];

  assign out_a[0] = 16'(out0);
  assign out_a[1] = 16'(out1);
  assign out_a[2] = 16'(out2);
  assign out_a[3] = 16'(out3);
  assign out_a[4] = 16'(out4);
  assign z_a[0] = z0;
  assign z_a[1] = z1;
  assign z_a[2] = z2;
  assign z_a[3] = z3;
  assign z_a[4] = z4;
  assign ovf_a[0] = ovf0;
  assign ovf_a[1] = ovf1;
  assign ovf_a[2] = ovf2;
  assign ovf_a[3] = ovf3;
  assign ovf_a[4] = ovf4;

  always #5 clk = ~clk;

  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(4), .SATURATE(1'b0))
    u0 (.clk(clk), .rst(rst), .in(in_b), .en(en), .clear(clear), .out(out0), .z(z0), .ovf(ovf0));
  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .CNT_W(4), .SATURATE(1'b0))
    u1 (.clk(clk), .rst(rst), .in(in_b), .en(en), .clear(clear), .out(out1), .z(z1), .ovf(ovf1));
  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .CNT_W(4), .SATURATE(1'b1))
    u2 (.clk(clk), .rst(rst), .in(in_b), .en(en), .clear(clear), .out(out2), .z(z2), .ovf(ovf2));
  mealy_seq_detector #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2), .SATURATE(1'b0))
    u3 (.clk(clk), .rst(rst), .in(in_b), .en(en), .clear(clear), .out(out3), .z(z3), .ovf(ovf3));
  mealy_seq_detector #(.PAT_W(5), .PATTERN(5'b10110), .OVERLAP(1'b0), .CNT_W(3), .SATURATE(1'b1))
    u4 (.clk(clk), .rst(rst), .in(in_b), .en(en), .clear(clear), .out(out4), .z(z4), .ovf(ovf4));

  // Reference model: accepted bits since the last reset / non-overlap match.
  bit hq [N][$];
  int cnt [N];
  bit movf [N];
  bit valid [N];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  function automatic bit mz(input int k);
    int v;
    int base;
    if (!rst || !en) return 1'b0;
    if (hq[k].size() < PW[k] - 1) return 1'b0;
    v = 0;
    base = hq[k].size() - (PW[k] - 1);
    for (int j = 0; j < PW[k] - 1; j++) v = (v << 1) | int'(hq[k][base + j]);
    v = (v << 1) | int'(in_b);
    return v == PAT[k];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rst) begin
        hq[k].delete();
        cnt[k] = 0;
        movf[k] = 1'b0;
        valid[k] = 1'b1;
      end else begin
        bit zz;
        int mx;
        zz = mz(k);
        mx = (1 << CW[k]) - 1;
        if (en) begin
          if (zz && OVL[k] == 0) hq[k].delete();
          else begin
            hq[k].push_back(in_b);
            if (hq[k].size() > 16) void'(hq[k].pop_front());
          end
        end
        if (clear) begin
          cnt[k] = 0;
          movf[k] = 1'b0;
        end else if (zz) begin
          if (cnt[k] == mx) begin
            movf[k] = 1'b1;
            cnt[k] = (SAT[k] != 0) ? mx : 0;
          end else cnt[k] = cnt[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (valid[k]) begin
        chk($sformatf("z[%0d]", k), int'(z_a[k]), int'(mz(k)));
        chk($sformatf("out[%0d]", k), int'(out_a[k]), cnt[k]);
        chk($sformatf("ovf[%0d]", k), int'(ovf_a[k]), int'(movf[k]));
      end
    end
  end

  task automatic cyc(input bit r, input bit e, input bit i, input bit c);
    @(posedge clk);
    #1;
    rst = r; en = e; in_b = i; clear = c;
    @(negedge clk);
  endtask

  initial begin
    bit s [7];
    bit ez0 [7];
    bit ez1 [7];
    int nz;
    s   = '{1, 1, 0, 1, 1, 0, 1};
    ez0 = '{0, 0, 0, 1, 0, 0, 1};
    ez1 = '{0, 0, 0, 1, 0, 0, 0};
    rst = 1'b0; en = 1'b1; in_b = 1'b1; clear = 1'b0;

    // Reset held with in=1, en=1
    @(negedge clk);
    chk("rst z", int'(z0), 0);
    chk("rst out", int'(out0), 0);
    chk("rst ovf", int'(ovf0), 0);
    cyc(0, 1, 1, 0);
    chk("rst z2", int'(z0), 0);
    chk("rst out2", int'(out0), 0);

    // Overlapping vs non-overlapping on 1101101
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1, s[i], 0);
      chk($sformatf("stream z0 bit%0d", i + 1), int'(z0), int'(ez0[i]));
      chk($sformatf("stream z1 bit%0d", i + 1), int'(z1), int'(ez1[i]));
    end
    cyc(1, 0, 0, 0);
    chk("stream out0", int'(out0), 2);
    chk("stream out1", int'(out1), 1);

    // Enable gap holds history
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 0);
      chk("gap z0", int'(z0), 0);
    end
    cyc(1, 1, 1, 0);
    chk("resume z0", int'(z0), 1);
    cyc(1, 0, 0, 0);
    chk("resume out0", int'(out0), 1);

    // Reset mid-pattern discards history
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 0, 0);
    cyc(0, 1, 1, 0);
    chk("midrst z0 in reset", int'(z0), 0);
    cyc(1, 1, 1, 0);
    chk("midrst z0 after", int'(z0), 0);
    cyc(1, 0, 0, 0);
    chk("midrst out0", int'(out0), 0);

    // Clear coinciding with a match
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 0); cyc(1, 1, 1, 0); cyc(1, 1, 0, 0);
    cyc(1, 1, 1, 1);
    chk("clear+match z0", int'(z0), 1);
    cyc(1, 0, 0, 0);
    chk("clear+match out0", int'(out0), 0);

    // 16 matches: wrap vs saturate, then clear
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 0);
    nz = 0;
    for (int m = 0; m < 16; m++) begin
      cyc(1, 1, 1, 0); nz += int'(z0);
      cyc(1, 1, 0, 0); nz += int'(z0);
      cyc(1, 1, 1, 0); nz += int'(z0);
    end
    chk("16 match pulses", nz, 16);
    cyc(1, 0, 0, 0);
    chk("wrap out0", int'(out0), 0);
    chk("wrap ovf0", int'(ovf0), 1);
    chk("sat out2", int'(out2), 15);
    chk("sat ovf2", int'(ovf2), 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    chk("clr out0", int'(out0), 0);
    chk("clr ovf0", int'(ovf0), 0);
    chk("clr out2", int'(out2), 0);
    chk("clr ovf2", int'(ovf2), 0);

    // Randomized traffic
    for (int t = 0; t < 3000; t++) begin
      cyc(bit'($urandom_range(0, 63) != 0), bit'($urandom_range(0, 3) != 0),
          bit'($urandom_range(0, 1)), bit'($urandom_range(0, 31) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
